// File: rtl/demux_1to4_reg_if.sv
// Bus bundle for demux_1to4_reg: one producer-side stream plus four
// consumer-side channels, each with payload, valid, ready and an 8-bit
// accepted-word counter.
interface demux_1to4_reg_if #(
  parameter int size = 32
) ();
  // producer side
  logic [size-1:0] data_i;
  logic [1:0]      select_i;
  logic            valid_i;
  logic            ready_o;
  // consumer side, one set per channel
  logic [size-1:0] data0_o, data1_o, data2_o, data3_o;
  logic            valid0_o, valid1_o, valid2_o, valid3_o;
  logic            ready0_i, ready1_i, ready2_i, ready3_i;
  logic [7:0]      cnt0_o, cnt1_o, cnt2_o, cnt3_o;

  // environment view: drives producer data and consumer readies
  modport master (
    output data_i, select_i, valid_i,
    output ready0_i, ready1_i, ready2_i, ready3_i,
    input  ready_o,
    input  data0_o, data1_o, data2_o, data3_o,
    input  valid0_o, valid1_o, valid2_o, valid3_o,
    input  cnt0_o, cnt1_o, cnt2_o, cnt3_o
  );

  // demux view
  modport slave (
    input  data_i, select_i, valid_i,
    input  ready0_i, ready1_i, ready2_i, ready3_i,
    output ready_o,
    output data0_o, data1_o, data2_o, data3_o,
    output valid0_o, valid1_o, valid2_o, valid3_o,
    output cnt0_o, cnt1_o, cnt2_o, cnt3_o
  );
endinterface

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake.
// Each output channel owns a one-entry holding register, so a stalled
// consumer only blocks words addressed to its own channel. ready_o is
// pass-through: a full channel whose consumer is ready can drain and
// reload in the same cycle.
// Optional feature macro: DEMUX_1TO4_CNT_EN enables saturating 8-bit
// per-channel accepted-word counters; without it cnt*_o are tied to zero.
module demux_1to4_reg #(
  parameter int size = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  demux_1to4_reg_if.slave  bus
);

  logic [size-1:0] data_r [4];
  logic [3:0]      valid_r;
  logic [3:0]      cons_ready_s;
  logic [3:0]      drain_s;
  logic [3:0]      acc_ch_s;
  logic            sel_ready_s;
  logic            acc_s;

  assign cons_ready_s = {bus.ready3_i, bus.ready2_i, bus.ready1_i, bus.ready0_i};
  assign drain_s      = valid_r & cons_ready_s;

  // Upstream ready: selected channel is empty or is being drained this cycle
  always_comb begin
    sel_ready_s = 1'b1;
    case (bus.select_i)
      2'd0:    sel_ready_s = ~valid_r[0] | cons_ready_s[0];
      2'd1:    sel_ready_s = ~valid_r[1] | cons_ready_s[1];
      2'd2:    sel_ready_s = ~valid_r[2] | cons_ready_s[2];
      2'd3:    sel_ready_s = ~valid_r[3] | cons_ready_s[3];
      default: sel_ready_s = 1'b1;
    endcase
  end

  assign acc_s = bus.valid_i & sel_ready_s;

  // One-hot load enable: only the selected channel is written on accept
  always_comb begin
    acc_ch_s = 4'b0000;
    if (acc_s) begin
      acc_ch_s[bus.select_i] = 1'b1;
    end else begin
      acc_ch_s = 4'b0000;
    end
  end

  // Holding registers: load wins over drain so drain+load keeps valid high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_r[k] <= {size{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc_ch_s[k]) begin
          data_r[k]  <= bus.data_i;
          valid_r[k] <= 1'b1;
        end else if (drain_s[k]) begin
          valid_r[k] <= 1'b0;
        end else begin
          valid_r[k] <= valid_r[k];
        end
      end
    end
  end

  assign bus.ready_o  = sel_ready_s;
  assign bus.data0_o  = data_r[0];
  assign bus.data1_o  = data_r[1];
  assign bus.data2_o  = data_r[2];
  assign bus.data3_o  = data_r[3];
  assign bus.valid0_o = valid_r[0];
  assign bus.valid1_o = valid_r[1];
  assign bus.valid2_o = valid_r[2];
  assign bus.valid3_o = valid_r[3];

`ifdef DEMUX_1TO4_CNT_EN
  logic [7:0] cnt_r [4];

  // Accepted-word counters, saturating at 255, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc_ch_s[k] && (cnt_r[k] != 8'd255)) begin
          cnt_r[k] <= cnt_r[k] + 8'd1;
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  assign bus.cnt0_o = cnt_r[0];
  assign bus.cnt1_o = cnt_r[1];
  assign bus.cnt2_o = cnt_r[2];
  assign bus.cnt3_o = cnt_r[3];
`else
  assign bus.cnt0_o = 8'd0;
  assign bus.cnt1_o = 8'd0;
  assign bus.cnt2_o = 8'd0;
  assign bus.cnt3_o = 8'd0;
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Scoreboard bench for demux_1to4_reg: stimulus pushes the hand-computed
// word per channel; a monitor pops and compares on every drain.
module tb_demux_1to4_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] q3[$];

  demux_1to4_reg_if #(.size(32)) bus ();
  demux_1to4_reg #(.size(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // producer stability rule while stalled
  property p_hold;
    @(posedge clk) disable iff (rst)
      (bus.valid_i && !bus.ready_o) |=> (bus.valid_i && $stable(bus.data_i) && $stable(bus.select_i));
  endproperty
  a_hold: assert property (p_hold);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dout(input int k);
    case (k)
      0: return bus.data0_o;
      1: return bus.data1_o;
      2: return bus.data2_o;
      default: return bus.data3_o;
    endcase
  endfunction

  function automatic logic vout(input int k);
    case (k)
      0: return bus.valid0_o;
      1: return bus.valid1_o;
      2: return bus.valid2_o;
      default: return bus.valid3_o;
    endcase
  endfunction

  function automatic logic rin(input int k);
    case (k)
      0: return bus.ready0_i;
      1: return bus.ready1_i;
      2: return bus.ready2_i;
      default: return bus.ready3_i;
    endcase
  endfunction

  function automatic logic [31:0] cnt_all();
    return {bus.cnt3_o, bus.cnt2_o, bus.cnt1_o, bus.cnt0_o};
  endfunction

  task automatic push(input int k, input logic [31:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  task automatic set_rdy(input logic [3:0] r);
    bus.ready0_i = r[0];
    bus.ready1_i = r[1];
    bus.ready2_i = r[2];
    bus.ready3_i = r[3];
  endtask

  // called at posedge+1; offers one word, waits bounded for acceptance
  task automatic send(input int k, input logic [31:0] w, output int waits);
    bit ok = 1'b0;
    waits = 0;
    bus.valid_i  = 1'b1;
    bus.select_i = k[1:0];
    bus.data_i   = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (ok) begin
      push(k, w);
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      chk($sformatf("latency_valid ch%0d", k), {63'd0, vout(k)}, 64'd1);
      chk($sformatf("latency_data ch%0d", k), {32'd0, dout(k)}, {32'd0, w});
    end else begin
      chk($sformatf("send_timeout ch%0d", k), 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
    end
  endtask

  // called at posedge+1; holds reset for n edges and drops queued words
  task automatic pulse_reset(input int n);
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // monitor: any channel that will drain at the next edge is compared
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          if (vout(k) && rin(k)) begin
            logic [31:0] e;
            int sz;
            case (k)
              0: sz = q0.size();
              1: sz = q1.size();
              2: sz = q2.size();
              default: sz = q3.size();
            endcase
            if (sz == 0) begin
              chk($sformatf("unexpected_word ch%0d", k), {32'd0, dout(k)}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
              endcase
              chk($sformatf("drain ch%0d", k), {32'd0, dout(k)}, {32'd0, e});
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    logic [31:0] exp_cnt;
    // reset with a word offered: must be discarded
    set_rdy(4'b1111);
    bus.valid_i  = 1'b1;
    bus.select_i = 2'd2;
    bus.data_i   = 32'hDEAD0002;
    @(negedge clk);
    chk("ready_in_reset", {63'd0, bus.ready_o}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("reset_valid", {60'd0, bus.valid3_o, bus.valid2_o, bus.valid1_o, bus.valid0_o}, 64'd0);
    chk("reset_data01", {bus.data1_o, bus.data0_o}, 64'd0);
    chk("reset_data23", {bus.data3_o, bus.data2_o}, 64'd0);
    chk("reset_cnt", {32'd0, cnt_all()}, 64'd0);
    chk("ready_after_reset", {63'd0, bus.ready_o}, 64'd1);
    @(posedge clk); #1;

    // basic routing, back-to-back
    for (int k = 0; k < 4; k++) begin
      send(k, 32'h10 + k, wt);
      chk($sformatf("route_no_stall ch%0d", k), wt, 64'd0);
    end

    // backpressure isolation on channel 2
    set_rdy(4'b1011);
    send(2, 32'hA, wt);
    fork
      send(2, 32'hB, wt);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_ready_low", {63'd0, bus.ready_o}, 64'd0);
          chk("bp_hold_data2", {32'd0, bus.data2_o}, 64'hA);
        end
        @(posedge clk); #1;
        bus.ready2_i = 1'b1;
      end
    join
    chk("bp_stall_cycles", wt, 64'd3);
    send(0, 32'hC, wt);
    chk("bp_ch0_no_stall", wt, 64'd0);

    // simultaneous drain and load on channel 1
    set_rdy(4'b1111);
    send(1, 32'h55, wt);
    send(1, 32'h66, wt);
    chk("drain_load_no_stall", wt, 64'd0);

    // mid-stream reset with channels 0 and 3 full
    set_rdy(4'b0110);
    send(0, 32'h30, wt);
    send(3, 32'h33, wt);
    pulse_reset(1);
    @(negedge clk);
    chk("midrst_valid", {60'd0, bus.valid3_o, bus.valid2_o, bus.valid1_o, bus.valid0_o}, 64'd0);
    chk("midrst_data03", {bus.data3_o, bus.data0_o}, 64'd0);
    @(posedge clk); #1;
    set_rdy(4'b1111);
    send(3, 32'h77, wt);

    // counters: 300 words to channel 1
    pulse_reset(1);
    for (int i = 0; i < 300; i++) begin
      send(1, 32'h1000 + i, wt);
      if (i == 9) begin
`ifdef DEMUX_1TO4_CNT_EN
        exp_cnt = 32'h0000_0A00;
`else
        exp_cnt = 32'd0;
`endif
        chk("cnt_after_10", {32'd0, cnt_all()}, {32'd0, exp_cnt});
      end
    end
`ifdef DEMUX_1TO4_CNT_EN
    exp_cnt = 32'h0000_FF00;
`else
    exp_cnt = 32'd0;
`endif
    @(negedge clk);
    chk("cnt_saturated", {32'd0, cnt_all()}, {32'd0, exp_cnt});

    // let everything drain and confirm every expected word was seen
    repeat (3) @(negedge clk);
    chk("q0_empty", q0.size(), 64'd0);
    chk("q1_empty", q1.size(), 64'd0);
    chk("q2_empty", q2.size(), 64'd0);
    chk("q3_empty", q3.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
